fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Pipelined RV32I instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage's control ROM.
- Owns the PC and issues requests to instruction memory using a read/resp handshake.
- Delivers the fetched instruction, its PC and the pre-sliced opcode/funct3/funct7 fields that drive the control word lookup.
- Handles decode stalls and branch/jump redirects from EX, including redirects that arrive while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0060, PC loaded at reset; first fetch address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_address  out  32  fetch address; registered, stable while imem_read is high.
- imem_read  out  1  fetch request; held high until imem_resp.
- imem_rdata  in  32  instruction word; valid when imem_resp=1.
- imem_resp  in  1  one-cycle response pulse.
- stall_i  in  1  decode cannot accept a new instruction; IF/ID holds.
- redirect_i  in  1  control transfer taken in EX.
- redirect_pc  in  32  new PC; sampled when redirect_i=1.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_instr  out  32  IF/ID instruction word.
- if_id_opcode  out  7  if_id_instr[6:0], combinational.
- if_id_funct3  out  3  if_id_instr[14:12], combinational.
- if_id_funct7  out  7  if_id_instr[31:25], combinational.

Behaviour:
- Reset, synchronous while rst=1:
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - imem_read=0, imem_address=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0, hold buffer cleared.
- First cycle after reset release: imem_read=1, imem_address=RESET_PC.
- Registers:
  - req_addr drives imem_address.
  - pc is the architectural next-fetch PC.
  - hold_instr/hold_pc form a one-entry skid buffer.
- imem_read is 1 in FETCH and DROP, 0 in HOLD. imem_address never changes while imem_read=1 and no imem_resp has arrived.
- FETCH, response arrives (imem_resp=1), checked in priority order:
  1. redirect_i=1: discard rdata; pc<=redirect_pc; req_addr<=redirect_pc; if_id_valid<=0; stay FETCH.
  2. stall_i=0: IF/ID<=(valid=1, pc, rdata); pc<=pc+4; req_addr<=pc+4; stay FETCH.
  3. stall_i=1: hold buffer<=(pc, rdata); go HOLD.
- FETCH, no response:
  - redirect_i=1: pc<=redirect_pc; if_id_valid<=0; go DROP. req_addr is unchanged because the in-flight request cannot be aborted.
  - Otherwise: if stall_i=0, if_id_valid<=0 (bubble); if stall_i=1, IF/ID holds.
- DROP (in-flight request to a stale address):
  - The first imem_resp is discarded; then req_addr<=pc and go FETCH.
  - A further redirect in DROP updates pc only; the last redirect wins.
  - if_id_valid stays 0.
- HOLD:
  - redirect_i=1: clear buffer; pc<=redirect_pc; req_addr<=redirect_pc; if_id_valid<=0; go FETCH.
  - Else stall_i=0: IF/ID<=buffer with valid=1; pc<=pc+4; req_addr<=pc+4; go FETCH.
  - Else: hold.
- Priority rules:
  - redirect_i outranks stall_i everywhere; a redirect always flushes IF/ID in the same edge.
  - rst outranks everything; reset mid-request returns to FETCH at RESET_PC, and any late imem_resp for the old request is the memory model's responsibility to suppress.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. redirect_pc is taken verbatim, with no alignment masking.
- Throughput: one instruction per cycle when memory responds every cycle after the request. Latency from imem_resp to if_id_valid=1 is 1 cycle.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (32) and perf_dropped (32), both reset to 0.
  - perf_fetched increments on every instruction written to IF/ID with valid=1.
  - perf_dropped increments on every discarded response (FETCH+redirect, DROP) and on every buffer cleared in HOLD by a redirect.
  - Both counters wrap modulo 2^32.
- FETCH_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then zero-latency memory returning 32'h0000_0013 → imem_address sequence 0x60, 0x64, 0x68; if_id_valid=1 from cycle 2; if_id_pc trails the fetch address by one fetch; opcode=7'h13.
- Response at 0x64 with stall_i=1 for 3 cycles → state HOLD, imem_read=0; IF/ID keeps 0x60 while stalled; 0x64 appears the cycle after stall drops; next request is 0x68.
- Redirect to 0x200 while a 2-cycle-latency request to 0x68 is pending → if_id_valid=0; imem_address stays 0x68 until resp; response discarded; next request 0x200; first valid if_id_pc=0x200.
- redirect_i=1 and stall_i=1 together with imem_resp=1 → rdata dropped; if_id_valid=0; next imem_address=redirect_pc.
- redirect_pc=32'hFFFF_FFFC → following fetch address 32'h0000_0000.
- With FETCH_PERF_CNT_EN, run the redirect scenario → perf_dropped=1 and perf_fetched equals the count of valid IF/ID loads; rst=1 mid-run clears both counters.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register, one-entry skid buffer and redirect drop.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_dropped counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic [2:0]  if_id_funct3,
  output logic [6:0]  if_id_funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_q, req_d;
  logic        vld_q, vld_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] hpc_q, hpc_d;
  logic [31:0] hins_q, hins_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    ins_d   = ins_q;
    hpc_d   = hpc_q;
    hins_d  = hins_q;
    unique case (state_q)
      FETCH: begin
        if (imem_resp) begin
          if (redirect_i) begin
            pc_d  = redirect_pc;
            req_d = redirect_pc;
            vld_d = 1'b0;
          end else if (!stall_i) begin
            vld_d = 1'b1;
            ipc_d = pc_q;
            ins_d = imem_rdata;
            pc_d  = pc_inc;
            req_d = pc_inc;
          end else begin
            hpc_d   = pc_q;
            hins_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect_i) begin
          // In-flight request can't be cancelled; keep req until it returns
          pc_d    = redirect_pc;
          vld_d   = 1'b0;
          state_d = DROP;
        end else if (!stall_i) begin
          vld_d = 1'b0;
        end
      end
      DROP: begin
        vld_d = 1'b0;
        if (redirect_i) pc_d = redirect_pc;
        if (imem_resp) begin
          req_d   = redirect_i ? redirect_pc : pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          hpc_d   = 32'd0;
          hins_d  = 32'd0;
          pc_d    = redirect_pc;
          req_d   = redirect_pc;
          vld_d   = 1'b0;
          state_d = FETCH;
        end else if (!stall_i) begin
          vld_d   = 1'b1;
          ipc_d   = hpc_q;
          ins_d   = hins_q;
          pc_d    = pc_inc;
          req_d   = pc_inc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      vld_q   <= 1'b0;
      ipc_q   <= 32'd0;
      ins_q   <= 32'd0;
      hpc_q   <= 32'd0;
      hins_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      ins_q   <= ins_d;
      hpc_q   <= hpc_d;
      hins_q  <= hins_d;
    end
  end

  assign imem_address = req_q;
  assign imem_read    = ~rst & (state_q != HOLD);
  assign if_id_valid  = vld_q;
  assign if_id_pc     = ipc_q;
  assign if_id_instr  = ins_q;
  assign if_id_opcode = ins_q[6:0];
  assign if_id_funct3 = ins_q[14:12];
  assign if_id_funct7 = ins_q[31:25];

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_evt;
  logic        drop_evt;
  logic [31:0] pf_q, pd_q;

  assign fetch_evt = ~redirect_i & ~stall_i &
    ((state_q == FETCH & imem_resp) | state_q == HOLD);
  assign drop_evt =
    (state_q == FETCH & imem_resp & redirect_i) |
    (state_q == DROP & imem_resp) |
    (state_q == HOLD & redirect_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q <= 32'd0;
      pd_q <= 32'd0;
    end else begin
      if (fetch_evt) pf_q <= pf_q + 32'd1;
      if (drop_evt)  pd_q <= pd_q + 32'd1;
    end
  end

  assign perf_fetched = pf_q;
  assign perf_dropped = pd_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage.
// Each row: inputs for one cycle and the registered outputs seen in it.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;
  logic [2:0]  if_id_funct3;
  logic [6:0]  if_id_funct7;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_opcode (if_id_opcode),
    .if_id_funct3 (if_id_funct3),
    .if_id_funct7 (if_id_funct7)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pf;
    logic [31:0] e_pd;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];
  int   n;
  int   applied;
  int   miscompares;
  bit   dropped;

  localparam logic [31:0] IA = 32'h0000_0013;
  localparam logic [31:0] IB = 32'h00A3_0393;
  localparam logic [31:0] IC = 32'h40B5_0533;
  localparam logic [31:0] ID = 32'hDEAD_BEEF;
  localparam logic [31:0] IE = 32'h0000_A0B7;
  localparam logic [31:0] IF = 32'h0020_9463;
  localparam logic [31:0] IG = 32'h0010_0073;
  localparam logic [31:0] IH = 32'h01C0_00EF;
  localparam logic [31:0] II = 32'h0081_2283;
  localparam logic [31:0] IJ = 32'h0062_A023;
  localparam logic [31:0] IX = 32'hCAFE_F00D;

  task automatic add(
    input logic r, input logic s, input logic rd,
    input logic [31:0] rpc, input logic rs, input logic [31:0] rdat,
    input logic er, input logic [31:0] ea, input logic ev,
    input logic [31:0] ep, input logic [31:0] ei,
    input logic [31:0] pf, input logic [31:0] pd);
    vecs[n].rst     = r;
    vecs[n].stall   = s;
    vecs[n].redir   = rd;
    vecs[n].rpc     = rpc;
    vecs[n].resp    = rs;
    vecs[n].rdata   = rdat;
    vecs[n].e_read  = er;
    vecs[n].e_addr  = ea;
    vecs[n].e_valid = ev;
    vecs[n].e_pc    = ep;
    vecs[n].e_instr = ei;
    vecs[n].e_pf    = pf;
    vecs[n].e_pd    = pd;
    n++;
  endtask

  logic [178:0] act, exp_v;
  logic [31:0]  ei;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $finish;
  end

  initial begin
    n = 0;
    applied = 0;
    miscompares = 0;
    //  rst s rd rpc            rs rdata  rd  addr           v  pc             instr pf pd
    add(1, 0, 0, 32'h0,         0, 32'h0, 0, 32'h60,         0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 0, 32'h0,         1, IA,    1, 32'h60,         0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 0, 32'h0,         1, IB,    1, 32'h64,         1, 32'h60,        IA,    1, 0);
    add(0, 1, 0, 32'h0,         1, IC,    1, 32'h68,         1, 32'h64,        IB,    2, 0);
    add(0, 1, 0, 32'h0,         0, IX,    0, 32'h68,         1, 32'h64,        IB,    2, 0);
    add(0, 1, 0, 32'h0,         0, IX,    0, 32'h68,         1, 32'h64,        IB,    2, 0);
    add(0, 0, 0, 32'h0,         0, IX,    0, 32'h68,         1, 32'h64,        IB,    2, 0);
    add(0, 0, 0, 32'h0,         0, IX,    1, 32'h6C,         1, 32'h68,        IC,    3, 0);
    add(0, 0, 1, 32'h200,       0, IX,    1, 32'h6C,         0, 32'h68,        IC,    3, 0);
    add(0, 0, 0, 32'h0,         0, IX,    1, 32'h6C,         0, 32'h68,        IC,    3, 0);
    add(0, 0, 0, 32'h0,         1, ID,    1, 32'h6C,         0, 32'h68,        IC,    3, 0);
    add(0, 0, 0, 32'h0,         1, IE,    1, 32'h200,        0, 32'h68,        IC,    3, 1);
    add(0, 1, 1, 32'hFFFF_FFFC, 1, IF,    1, 32'h204,        1, 32'h200,       IE,    4, 1);
    add(0, 0, 0, 32'h0,         1, IG,    1, 32'hFFFF_FFFC,  0, 32'h200,       IE,    4, 2);
    add(0, 0, 0, 32'h0,         1, IH,    1, 32'h0,          1, 32'hFFFF_FFFC, IG,    5, 2);
    add(0, 1, 0, 32'h0,         1, II,    1, 32'h4,          1, 32'h0,         IH,    6, 2);
    add(0, 1, 1, 32'h300,       0, IX,    0, 32'h4,          1, 32'h0,         IH,    6, 2);
    add(0, 0, 0, 32'h0,         0, IX,    1, 32'h300,        0, 32'h0,         IH,    6, 3);
    add(0, 0, 1, 32'h400,       0, IX,    1, 32'h300,        0, 32'h0,         IH,    6, 3);
    add(0, 0, 1, 32'h500,       0, IX,    1, 32'h300,        0, 32'h0,         IH,    6, 3);
    add(0, 0, 0, 32'h0,         1, IX,    1, 32'h300,        0, 32'h0,         IH,    6, 3);
    add(0, 0, 0, 32'h0,         1, IJ,    1, 32'h500,        0, 32'h0,         IH,    6, 4);
    add(1, 0, 0, 32'h0,         0, IX,    0, 32'h504,        1, 32'h500,       IJ,    7, 4);
    add(1, 0, 0, 32'h0,         0, IX,    0, 32'h60,         0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 0, 32'h0,         1, IA,    1, 32'h60,         0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 0, 32'h0,         0, IX,    1, 32'h64,         1, 32'h60,        IA,    1, 0);

    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc = 32'h0;
    imem_resp = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    #1;
    if (imem_read !== 1'b0 || imem_address !== 32'h60 ||
        if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
        if_id_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: rd=%b a=%h v=%b pc=%h i=%h",
               imem_read, imem_address, if_id_valid,
               if_id_pc, if_id_instr);
    end

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      stall_i     = vecs[i].stall;
      redirect_i  = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      imem_resp   = vecs[i].resp;
      imem_rdata  = vecs[i].rdata;
      #1;
      ei = vecs[i].e_instr;
      act = '0;
      exp_v = '0;
      act[114:0] = {imem_read, imem_address, if_id_valid, if_id_pc,
                    if_id_instr, if_id_opcode, if_id_funct3, if_id_funct7};
      exp_v[114:0] = {vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_pc, ei, ei[6:0], ei[14:12], ei[31:25]};
`ifdef FETCH_PERF_CNT_EN
      act[178:115] = {perf_fetched, perf_dropped};
      exp_v[178:115] = {vecs[i].e_pf, vecs[i].e_pd};
`endif
      applied++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL vec%0d: got %h want %h", i, act, exp_v);
      end
    end

    dropped = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst        = 1'b0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      imem_resp  = 1'b0;
      #1;
      if (if_id_valid === 1'b0) begin
        dropped = 1'b1;
        break;
      end
    end
    if (!dropped) begin
      miscompares++;
      $display("FAIL wait expired: if_id_valid never dropped");
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
